// File: rtl/rx_pkt_commit_fifo.sv
// Receive packet FIFO: frames are buffered tentatively and become readable only once their
// EOP arrives without error; errored or overflowing frames are rolled back and counted.
module rx_pkt_commit_fifo #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_eop,
  input  logic              wr_err,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_eop,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PW    = ADDR_W + 1;
  localparam logic [PW-1:0]    DEPTH_P  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PW-1:0]    PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {ST_ACCEPT, ST_DROP} wr_state_t;

  wr_state_t state_q;

  // wr_ptr: tentative end, cm_ptr: committed end, rd_ptr: next word to hand over,
  // fe_ptr: next word to fetch into the read pipeline (rd_ptr <= fe_ptr <= cm_ptr).
  logic [PW-1:0] wr_ptr_q, cm_ptr_q, rd_ptr_q, fe_ptr_q;
  logic [PW-1:0] occ;

  logic [DATA_W:0] mem [DEPTH];
  logic [DATA_W:0] ram_q;
  logic            ram_vld_q;

  logic [DATA_W:0] head_q, tail_q;
  logic [1:0]      out_cnt_q;

  logic [CNT_W-1:0] pkt_count_q, drop_count_q;

  logic has_room, accept, store, commit, drop;
  logic pop, eop_pop, issue;
  logic [2:0] inflight, inflight_limit;

  assign occ      = wr_ptr_q - rd_ptr_q;
  assign has_room = (occ != DEPTH_P);
  assign accept   = (state_q == ST_ACCEPT) && wr_en;
  assign store    = accept && has_room;
  assign commit   = store && wr_eop && !wr_err;
  assign drop     = accept && (!has_room || (wr_eop && wr_err));

  assign pop     = (out_cnt_q != 2'd0) && rd_ready;
  assign eop_pop = pop && head_q[DATA_W];

  // Words in flight (RAM register plus skid) may never exceed the two skid slots.
  assign inflight       = {1'b0, out_cnt_q} + {2'b0, ram_vld_q};
  assign inflight_limit = 3'd2 + {2'b0, pop};
  assign issue          = (fe_ptr_q != cm_ptr_q) && (inflight < inflight_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCEPT;
      wr_ptr_q     <= '0;
      cm_ptr_q     <= '0;
      drop_count_q <= '0;
    end else begin
      case (state_q)
        ST_ACCEPT: begin
          if (wr_en) begin
            if (has_room) begin
              if (wr_eop && wr_err) begin
                wr_ptr_q <= cm_ptr_q;
              end else begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
              end
              if (wr_eop && !wr_err) begin
                cm_ptr_q <= wr_ptr_q + PTR_ONE;
              end
            end else begin
              wr_ptr_q <= cm_ptr_q;
              if (!wr_eop) begin
                state_q <= ST_DROP;
              end
            end
          end
        end
        ST_DROP: begin
          if (wr_en && wr_eop) begin
            state_q <= ST_ACCEPT;
          end
        end
        default: state_q <= ST_ACCEPT;
      endcase
      if (drop && (drop_count_q != {CNT_W{1'b1}})) begin
        drop_count_q <= drop_count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_q <= '0;
    end else if (commit && !eop_pop) begin
      pkt_count_q <= pkt_count_q + CNT_ONE;
    end else if (!commit && eop_pop) begin
      pkt_count_q <= pkt_count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= {wr_eop, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      ram_q <= mem[fe_ptr_q[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fe_ptr_q  <= '0;
      ram_vld_q <= 1'b0;
    end else begin
      ram_vld_q <= issue;
      if (issue) begin
        fe_ptr_q <= fe_ptr_q + PTR_ONE;
      end
    end
  end

  // Output skid: head drives the read port and only moves on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      out_cnt_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      out_cnt_q <= out_cnt_q + {1'b0, ram_vld_q} - {1'b0, pop};
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        if (out_cnt_q == 2'd2) begin
          head_q <= tail_q;
          if (ram_vld_q) begin
            tail_q <= ram_q;
          end
        end else if (ram_vld_q) begin
          head_q <= ram_q;
        end
      end else if (ram_vld_q) begin
        if (out_cnt_q == 2'd0) begin
          head_q <= ram_q;
        end else begin
          tail_q <= ram_q;
        end
      end
    end
  end

  assign rd_valid   = (out_cnt_q != 2'd0);
  assign rd_data    = head_q[DATA_W-1:0];
  assign rd_eop     = head_q[DATA_W];
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
  assign empty      = (cm_ptr_q == rd_ptr_q);
  assign full       = (occ == DEPTH_P);

endmodule
